// File: rtl/aes_dec_arb_pkg.sv
// Shared encodings for the AES decipher arbiter: FSM states, key-length codes, default watchdog limit.
package aes_dec_arb_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 128;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last_grant, with wrap-around.
// Zero latency; no state, the caller decides when a grant is taken.
module aes_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  logic [ID_W-1:0] pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_vld && req_valid[pos]) begin
        grant_vld      = 1'b1;
        grant[pos]     = 1'b1;
        grant_idx      = pos;
      end
    end
  end

endmodule

// File: rtl/aes_decipher_arbiter.sv
// Shares one AES decipher core among NUM_REQ requesters; one request in flight, response held until owner's resp_ready.
// Optional watchdog under AES_DEC_ARB_TIMEOUT_EN returns resp_err=1 with a zero block when the core never finishes.
module aes_decipher_arbiter
  import aes_dec_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_block,
  input  logic [NUM_REQ-1:0]     req_keylen,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [127:0]           resp_block,
  output logic                   resp_err,
  output logic                   core_next,
  output logic                   core_keylen,
  output logic [127:0]           core_block,
  output logic [ID_W-1:0]        core_key_sel,
  input  logic                   core_ready,
  input  logic [127:0]           core_result
);

  if (ID_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("aes_decipher_arbiter: ID_W must equal clog2(NUM_REQ) and TIMEOUT_CYCLES must be >= 2");
  end

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [ID_W-1:0]    last_grant;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_vld;
  logic [127:0]       sel_block;
  logic               sel_keylen;
  logic [NUM_REQ-1:0] owner_onehot;
  logic               take;
  logic               capture;
  logic               release_resp;
  logic               tmo;

  aes_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  always_comb begin
    sel_block  = '0;
    sel_keylen = AES_128_BIT_KEY;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_block  = req_block[i*128 +: 128];
        sel_keylen = req_keylen[i];
      end
    end
  end

  // core_key_sel doubles as the owner index from ISSUE through RESP.
  assign owner_onehot = NUM_REQ'(1) << core_key_sel;

`ifdef AES_DEC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign tmo = (state == WAIT_BUSY || state == WAIT_DONE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant_vld && core_ready) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tmo)             state_nxt = RESP;
        else if (!core_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (core_ready || tmo) state_nxt = RESP;
      RESP:      if (resp_ready[core_key_sel]) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state == IDLE && core_ready) ? grant : '0;
    take         = (state == IDLE) && core_ready && grant_vld;
    capture      = (state == WAIT_DONE) && core_ready;
    release_resp = (state == RESP) && resp_ready[core_key_sel];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_next    <= 1'b0;
      core_block   <= '0;
      core_keylen  <= AES_128_BIT_KEY;
      core_key_sel <= '0;
      resp_valid   <= '0;
      resp_block   <= '0;
      resp_err     <= 1'b0;
      last_grant   <= ID_W'(NUM_REQ - 1);
    end else begin
      core_next <= take;
      if (take) begin
        core_block   <= sel_block;
        core_keylen  <= sel_keylen;
        core_key_sel <= grant_idx;
      end
      // Completion wins over a watchdog expiry landing on the same cycle.
      if (capture) begin
        resp_block <= core_result;
        resp_valid <= owner_onehot;
        resp_err   <= 1'b0;
      end else if (tmo) begin
        resp_block <= '0;
        resp_valid <= owner_onehot;
        resp_err   <= 1'b1;
      end else if (release_resp) begin
        resp_valid <= '0;
        resp_err   <= 1'b0;
        last_grant <= core_key_sel;
      end
    end
  end

endmodule

// File: doc/aes_decipher_arbiter.md
Name: aes_decipher_arbiter

Overview:
Round-robin arbiter and sequencer that shares one aes_decipher_block instance among NUM_REQ requesters.
- Accepts per-requester decipher requests (valid/ready).
- Latches the winning request's block and keylen and issues the single-cycle core_next pulse.
- Tracks the core's ready handshake and returns the result to the owning requester.
- Drives core_key_sel so the external key-expansion/round-key store serves the owner's key set.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, width of requester index; must equal clog2(NUM_REQ).
TIMEOUT_CYCLES, 128, watchdog limit in cycles; used only with AES_DEC_ARB_TIMEOUT_EN.

Ports:
clk  in  1  clock.
reset_n  in  1  reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  one-hot accept pulse.
req_block  in  NUM_REQ*128  ciphertext per requester; requester i occupies bits [128*i+127 : 128*i].
req_keylen  in  NUM_REQ  0 = AES-128, 1 = AES-256.
resp_valid  out  NUM_REQ  one-hot response valid.
resp_ready  in  NUM_REQ  per-requester response accept.
resp_block  out  128  plaintext for the current owner.
resp_err  out  1  timeout flag, qualified by resp_valid.
core_next  out  1  start pulse to the decipher core.
core_keylen  out  1  keylen to the core.
core_block  out  128  block to the core.
core_key_sel  out  ID_W  owner index, to the round-key store.
core_ready  in  1  core ready.
core_result  in  128  core new_block.

Behaviour:
Reset and clocking:
- reset is reset_n, asynchronous, active-low; clock is clk.
- On reset: state IDLE; req_ready=0; resp_valid=0; resp_block=0; resp_err=0; core_next=0; core_block=0; core_keylen=0; core_key_sel=0; last_grant=NUM_REQ-1.
- All outputs are registered except req_ready. req_ready is a combinational decode of the grant in IDLE.

FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if any req_valid and core_ready=1, grant the first valid index searching from last_grant+1 with wrap-around modulo NUM_REQ.
  - Assert req_ready[g] in that cycle.
  - Latch req_block[g] into core_block, req_keylen[g] into core_keylen, and g into core_key_sel.
  - Go to ISSUE.
  - If core_ready=0, nothing is granted.
- ISSUE: core_next=1 for exactly this one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until core_ready=0, then go to WAIT_DONE. The core drops ready one cycle after next.
- WAIT_DONE: stay until core_ready=1.
  - Then capture core_result into resp_block, set resp_valid[owner]=1, and go to RESP.
- RESP: hold resp_valid and resp_block stable until resp_ready[owner]=1.
  - Then clear resp_valid, set last_grant=owner, and go to IDLE.
  - resp_ready on non-owner bits is ignored.

Stability and throughput:
- core_block, core_keylen and core_key_sel stay stable from ISSUE through RESP. The core samples block one cycle after next, and round_key is indexed live through the core's round output.
- Minimum accept-to-accept spacing is 1 + core latency + 3 cycles. No back-to-back overlap; one request is in flight at a time.

Boundary conditions:
- Requester with req_valid=1 on the grant cycle: it is not re-granted next unless it is the only valid requester. Round-robin fairness guarantees service within NUM_REQ grants.
- req_valid dropped before grant: legal; the request is simply not seen.
- resp_ready already high when resp_valid rises: the response completes in one RESP cycle.
- Reset mid-operation: the FSM aborts to IDLE and no response is produced. The core shares reset_n and is reset alongside.

Optional Feature:
AES_DEC_ARB_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to WAIT_BUSY and increments every cycle in WAIT_BUSY/WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1 without completion, go to RESP with resp_block=0 and resp_err=1.
  - resp_err clears with resp_valid.
- Undefined: no counter, resp_err tied 0, and WAIT_* states wait indefinitely.

Decomposition:
- Package aes_dec_arb_pkg holds:
  - FSM state encodings (3-bit localparams).
  - Keylen encodings AES_128_BIT_KEY=0 and AES_256_BIT_KEY=1.
  - Default TIMEOUT_CYCLES.
- One natural sub-module, aes_rr_arbiter: combinational round-robin pick of a one-hot grant plus index from req_valid and last_grant.

Test Plan:
- Single request from requester 0 with AES-128 key 000102..0f in the key store and block 69c4e0d86a7b0430d8cdb78070b4c55a -> core_next is a one-cycle pulse, core_key_sel=0, resp_valid[0] with resp_block 00112233445566778899aabbccddeeff.
- AES-256 request from requester 2 with key 000102..1f and block 8ea2b7ca516745bfeafc49904b496089 -> core_keylen=1, core_key_sel=2, resp_block 00112233445566778899aabbccddeeff.
- All four requesters valid continuously after reset -> grant order 0,1,2,3,0; each result routed to the correct resp_valid bit.
- Owner holds resp_ready=0 for 10 cycles -> resp_valid and resp_block stable, no new core_next, other req_ready stay 0.
- Assert reset_n low during WAIT_DONE -> all outputs at reset values next cycle; after release a fresh request completes correctly.
- With AES_DEC_ARB_TIMEOUT_EN and core_ready model stuck at 0 -> resp_valid with resp_err=1 and resp_block=0 after TIMEOUT_CYCLES; without the macro, no response.
